dec_down_timer: RTL and testbench

- Loadable decimal countdown timer; the down-counting counterpart of the team's modulo-1000 up-counter.
- Counts a programmed value down to 0 at one step per clock.
- Signals terminal count, and in periodic mode reloads the programmed value after 0.
- Drives a binary count and a 3-digit BCD count, so the value can feed seven-segment display logic without a separate converter.

---
 rtl/dec_timer_pkg.sv | 24 ++
 rtl/dec_down_timer_digit.sv | 31 +++
 rtl/dec_down_timer.sv | 131 +++++++++++++
 tb/tb_dec_down_timer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dec_timer_pkg.sv
// dec_timer_pkg: shared types/helpers for the decimal down timer.
// Holds the FSM state enum, digit count and the load-time BCD encoder.
package dec_timer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int BCD_DIGITS = 3;

  function automatic logic [11:0] bin2bcd3(
    input logic [9:0] v
  );
    logic [3:0] h;
    logic [3:0] t;
    logic [3:0] o;
    h = 4'(v / 10'd100);
    t = 4'((v / 10'd10) % 10'd10);
    o = 4'(v % 10'd10);
    return {h, t, o};
  endfunction

endpackage

// File: rtl/dec_down_timer_digit.sv
// bcd_digit_dn: one BCD digit that loads or counts down.
// Ports: clk, rst (async low), ld/ld_val, dec, digit, borrow_out.
module bcd_digit_dn (
  input  logic       clk,
  input  logic       rst,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic       dec,
  output logic [3:0] digit,
  output logic       borrow_out
);

  // Borrow ripples to the next digit in the
  // same cycle this digit wraps 0 -> 9.
  assign borrow_out = dec && (digit == 4'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit <= 4'd0;
    end else if (ld) begin
      digit <= ld_val;
    end else if (dec) begin
      if (digit == 4'd0) begin
        digit <= 4'd9;
      end else begin
        digit <= digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/dec_down_timer.sv
// dec_down_timer: loadable decimal countdown, one-shot or periodic.
// Ports: clk, rst (async low), load/load_val, start, stop, periodic,
// busy, tc, out (binary), bcd (3 BCD digits).
module dec_down_timer
  import dec_timer_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int MAX   = 999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  output logic             busy,
  output logic             tc,
  output logic [WIDTH-1:0] out,
  output logic [11:0]      bcd
);

  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO = '0;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(MAX);

  state_t           state, state_n;
  logic [WIDTH-1:0] out_n;
  logic [WIDTH-1:0] rl, rl_n;
  logic [11:0]      rl_bcd, rl_bcd_n;
  logic             tc_n;
  logic [WIDTH-1:0] sat;
  logic [11:0]      sat_bcd;

  logic             dig_ld;
  logic [11:0]      dig_ld_val;
  logic             dec_en;

  assign sat = (load_val > SMAX) ? SMAX : load_val;
  assign sat_bcd = bin2bcd3(sat[9:0]);

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      out    <= '0;
      rl     <= '0;
      rl_bcd <= '0;
      tc     <= 1'b0;
    end else begin
      state  <= state_n;
      out    <= out_n;
      rl     <= rl_n;
      rl_bcd <= rl_bcd_n;
      tc     <= tc_n;
    end
  end

  always_comb begin
    state_n    = state;
    out_n      = out;
    rl_n       = rl;
    rl_bcd_n   = rl_bcd;
    tc_n       = 1'b0;
    dig_ld     = 1'b0;
    dig_ld_val = '0;
    dec_en     = 1'b0;
    if (load) begin
      out_n      = sat;
      rl_n       = sat;
      rl_bcd_n   = sat_bcd;
      state_n    = IDLE;
      dig_ld     = 1'b1;
      dig_ld_val = sat_bcd;
    end else if (stop) begin
      state_n = IDLE;
    end else if (start && state == IDLE) begin
      if (out != ZERO) begin
        state_n = RUN;
      end
    end else if (state == RUN) begin
      unique case (1'b1)
        (out > ONE): begin
          out_n  = out - ONE;
          dec_en = 1'b1;
        end
        (out == ONE): begin
          out_n  = ZERO;
          dec_en = 1'b1;
          tc_n   = 1'b1;
          if (!periodic) begin
            state_n = IDLE;
          end
        end
        default: begin
          // Zero in RUN only persists while periodic:
          // reload keeps the period at N+1.
          if (periodic) begin
            out_n      = rl;
            dig_ld     = 1'b1;
            dig_ld_val = rl_bcd;
          end else begin
            state_n = IDLE;
          end
        end
      endcase
    end
  end

  logic [BCD_DIGITS-1:0][3:0] dig;
  logic [BCD_DIGITS:0]        dec_c;
  logic                       unused_borrow;

  assign dec_c[0]      = dec_en;
  assign unused_borrow = dec_c[BCD_DIGITS];
  assign bcd           = dig;

  for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_dig
    bcd_digit_dn u_dig (
      .clk        (clk),
      .rst        (rst),
      .ld         (dig_ld),
      .ld_val     (dig_ld_val[i*4 +: 4]),
      .dec        (dec_c[i]),
      .digit      (dig[i]),
      .borrow_out (dec_c[i+1])
    );
  end

endmodule

// File: tb/tb_dec_down_timer.sv
// tb_dec_down_timer: scoreboard bench for dec_down_timer.
// Expected per-edge results are queued at drive time, popped after the edge.
module tb_dec_down_timer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load = 1'b0;
  logic [31:0] load_val = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        periodic = 1'b0;
  logic        busy;
  logic        tc;
  logic [31:0] out;
  logic [11:0] bcd;

  int total = 0;
  int bad   = 0;
  int nstep = 0;
  int tcs;

  typedef struct {
    logic [31:0] out;
    logic [11:0] bcd;
    logic        busy;
    logic        tc;
  } exp_t;

  exp_t q[$];

  int m_out, m_rl;
  bit m_run, m_tc;

  always #5 clk = ~clk;

  dec_down_timer #(.WIDTH(32), .MAX(999)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .start    (start),
    .stop     (stop),
    .periodic (periodic),
    .busy     (busy),
    .tc       (tc),
    .out      (out),
    .bcd      (bcd)
  );

  function automatic logic [11:0] tobcd(input int v);
    logic [3:0] h, t, o;
    h = 4'((v / 100) % 10);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit ld, input int v, input bit st,
                       input bit sp, input bit per);
    m_tc = 1'b0;
    if (ld) begin
      m_out = (v > 999) ? 999 : v;
      m_rl  = m_out;
      m_run = 1'b0;
    end else if (sp) begin
      m_run = 1'b0;
    end else if (st && !m_run) begin
      if (m_out != 0) m_run = 1'b1;
    end else if (m_run) begin
      if (m_out > 1) begin
        m_out--;
      end else if (m_out == 1) begin
        m_out = 0;
        m_tc  = 1'b1;
        if (!per) m_run = 1'b0;
      end else if (per) begin
        m_out = m_rl;
      end else begin
        m_run = 1'b0;
      end
    end
  endtask

  task automatic step(input bit ld, input int v, input bit st,
                      input bit sp, input bit per);
    exp_t e;
    exp_t g;
    @(negedge clk);
    load     = ld;
    load_val = v;
    start    = st;
    stop     = sp;
    periodic = per;
    model(ld, v, st, sp, per);
    e.out  = m_out;
    e.bcd  = tobcd(m_out);
    e.busy = m_run;
    e.tc   = m_tc;
    q.push_back(e);
    @(posedge clk);
    #1;
    nstep++;
    g = q.pop_front();
    chk($sformatf("out@%0d", nstep), out, g.out);
    chk($sformatf("bcd@%0d", nstep), 32'(bcd), 32'(g.bcd));
    chk($sformatf("busy@%0d", nstep), 32'(busy), 32'(g.busy));
    chk($sformatf("tc@%0d", nstep), 32'(tc), 32'(g.tc));
    if (tc) tcs++;
  endtask

  task automatic idle(input int n, input bit per);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, per);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out"}, out, 32'd0);
    chk({tag, "_bcd"}, 32'(bcd), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_tc"}, 32'(tc), 32'd0);
  endtask

  initial begin
    m_out = 0;
    m_rl  = 0;
    m_run = 1'b0;
    m_tc  = 1'b0;
    #12;
    chk_reset("rst0");
    @(negedge clk);
    rst = 1'b1;

    // start with out==0 is ignored
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);

    // one-shot 3,3,2,1,0
    step(1, 3, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(6, 0);

    // saturation, then load beats stop/start
    step(1, 1500, 0, 0, 0);
    chk("sat_bcd", 32'(bcd), 32'h999);
    step(0, 0, 1, 0, 0);
    idle(2, 0);
    step(1, 7, 1, 1, 0);
    chk("ldpri_out", out, 32'd7);

    // pause at 6, resume
    step(1, 10, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(4, 0);
    step(0, 0, 0, 1, 0);
    chk("pause_out", out, 32'd6);
    idle(3, 0);
    step(0, 0, 1, 0, 0);
    idle(3, 0);

    // periodic 100 with BCD borrow chain
    step(1, 100, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    tcs = 0;
    idle(205, 1);
    chk("per_tcs", tcs, 32'd2);

    // periodic dropped while at zero
    step(1, 2, 0, 0, 1);
    step(0, 0, 1, 0, 1);
    idle(2, 1);
    idle(3, 0);

    // async reset mid-run
    step(1, 5, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    idle(2, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_reset("rstmid");
    m_out = 0;
    m_rl  = 0;
    m_run = 1'b0;
    m_tc  = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 1, 0, 0);

    chk("q_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
